pixel_scan_gen: RTL and testbench
=================================

PIXEL_SCAN_GEN -- requirements
Module: pixel_scan_gen

Interface
- REQ-001 SHALL have parameter WIDTH, default 640, active pixels per line; multiple of 4, range 4..1020.
- REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame; range 1..1023.
- REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
- REQ-004 SHALL have port areset  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port enable  input  1  frame-run request, sampled only at frame boundaries.
- REQ-006 SHALL have port pattern  input  2  pattern select, sampled only at frame start.
- REQ-007 SHALL have port solid_rgb  input  24  {r,g,b} colour for pattern 3, sampled only at frame start.
- REQ-008 SHALL have port r, g, b  output  8 each  pixel colour.
- REQ-009 SHALL have port valid  output  1  pixel present.
- REQ-010 SHALL have port ready  input  1  downstream packer accepts pixel when valid&ready.
- REQ-011 SHALL have port sof  output  1  high only on pixel (0,0).
- REQ-012 SHALL have port eol  output  1  high only on pixel x=WIDTH-1.
- REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
- REQ-014 SHALL implement FSM IDLE/RUN; IDLE->RUN when enable=1 in IDLE; RUN->IDLE when last pixel (WIDTH-1,HEIGHT-1) is accepted and enable=0; if enable=1 at that point, SHALL stay in RUN and start the next frame with no gap cycle.
- REQ-015 SHALL register all outputs; first pixel (0,0) SHALL appear with valid=1 in the cycle after enable is seen high in IDLE.
- REQ-016 SHALL keep r,g,b,sof,eol stable and valid high until accepted; valid SHALL never drop without acceptance while in RUN.
- REQ-017 SHALL advance raster order on acceptance: x increments; at x=WIDTH-1, x wraps to 0 and y increments; at (WIDTH-1,HEIGHT-1), both wrap to 0.
- REQ-018 SHALL use 10-bit x and y counters plus an 8-bit frame counter, incremented modulo 256 on last-pixel acceptance.
- REQ-019 SHALL latch pattern and solid_rgb when pixel (0,0) is generated; mid-frame changes SHALL have no effect.
- REQ-020 SHALL produce the following patterns:
  - 0: r=x[7:0], g=y[7:0], b=0.
  - 1: white (FFFFFF) when x[3]^y[3]=1, else black.
  - 2: eight vertical bars of width WIDTH/8, colours in bar order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 3: latched solid_rgb.
- REQ-021 SHALL hold valid=0 in IDLE; enable deassertion mid-frame SHALL NOT truncate the frame.
- REQ-022 SHALL, when ready=1 continuously, deliver one pixel per cycle.

Reset
- REQ-023 SHALL on areset=1 force IDLE, x=y=0, frame=0, valid=0, sof=0, eol=0, busy=0, r=g=b=0, regardless of handshake state.
- REQ-024 SHALL, after reset mid-frame, restart from (0,0) with sof=1 on the next enabled frame.

Configuration
- REQ-025 SHALL support macro PIXEL_SCAN_ANIMATE_EN: when defined, patterns 0 and 1 add frame[7:0] to x before colour mapping (b of pattern 0 = frame); when undefined, the frame counter has no effect on colour and pattern 0 has b=0.

Structure
- REQ-026 SHALL place the FSM state encoding, pattern codes, and the bar-colour table in shared package pixel_pkg.
- REQ-027 SHALL implement the x/y/frame/pattern-to-RGB mapping as combinational sub-module pattern_map; the FSM, counters, and output register stay in pixel_scan_gen.

Verification
- REQ-028 SHALL include reset/start: WIDTH=8, HEIGHT=2, ready=1, enable pulse one cycle -> 16 consecutive valid cycles; sof on first; eol on pixels 7 and 15; busy falls after the 16th.
- REQ-029 SHALL include backpressure: ready toggling 1,0,0,1 -> pixel held stable across ready=0 cycles; no pixel skipped or duplicated; pattern 0 gives r=0..7.
- REQ-030 SHALL include back-to-back frames: enable held high for 2 frames -> second sof immediately follows last pixel; frame counter 0->1->2.
- REQ-031 SHALL include a mid-frame pattern change: pattern=1 at frame start, switched to 3 at pixel 5 -> checkerboard for whole frame; 3 applies next frame.
- REQ-032 SHALL include mid-frame reset: areset at pixel (3,1) -> next cycle valid=0, busy=0; next enable restarts at (0,0) with sof=1.
- REQ-033 SHALL include the macro check: with PIXEL_SCAN_ANIMATE_EN, frame 2 pattern 0 pixel (0,0) -> r=02, b=02; without it -> r=00, b=00.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel scan generator.
package pixel_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned RGB_W   = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PAT_GRAD  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour-bar table, index 0 is the leftmost bar.
  localparam logic [7:0][RGB_W-1:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/pattern_map.sv
// Combinational x/y/frame/pattern to RGB mapping.
// PIXEL_SCAN_ANIMATE_EN: patterns 0 and 1 scroll horizontally with the frame counter.
module pattern_map
  import pixel_pkg::*;
#(
  parameter int unsigned WIDTH = 640
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [FRAME_W-1:0] frame,
  input  pattern_e           pattern,
  input  logic [RGB_W-1:0]   solid_rgb,
  output rgb_t               rgb_c
);

  logic [7:0] xa;
  logic [7:0] bz;
  logic [2:0] bar;
  logic       coord_unused;

`ifdef PIXEL_SCAN_ANIMATE_EN
  assign xa = x[7:0] + frame;
  assign bz = frame;
`else
  logic frame_unused;
  assign frame_unused = ^frame;
  assign xa = x[7:0];
  assign bz = 8'h00;
`endif

  assign coord_unused = ^y[COORD_W-1:8];

  // Scaling by 8 before dividing keeps bar width WIDTH/8 without a zero divisor.
  assign bar = 3'((32'(x) * 32'd8) / WIDTH);

  always_comb begin
    rgb_c = '0;
    case (pattern)
      PAT_GRAD:  rgb_c = '{r: xa, g: y[7:0], b: bz};
      PAT_CHECK: rgb_c = (xa[3] ^ y[3]) ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
      PAT_BARS:  rgb_c = rgb_t'(BAR_RGB[bar]);
      PAT_SOLID: rgb_c = rgb_t'(solid_rgb);
      default:   rgb_c = '0;
    endcase
  end

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster pixel generator with valid/ready output and IDLE/RUN frame control.
// Build option PIXEL_SCAN_ANIMATE_EN is implemented in pattern_map.
module pixel_scan_gen
  import pixel_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [1:0]        pattern,
  input  logic [RGB_W-1:0]  solid_rgb,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              valid,
  input  logic              ready,
  output logic              sof,
  output logic              eol,
  output logic              busy
);

  state_e             state, state_nxt;
  logic [COORD_W-1:0] x_q, x_nxt;
  logic [COORD_W-1:0] y_q, y_nxt;
  logic [FRAME_W-1:0] frame_q, frame_nxt;
  pattern_e           pat_q, pat_nxt;
  logic [RGB_W-1:0]   solid_q, solid_nxt;
  logic               valid_nxt, sof_nxt, eol_nxt, start;
  logic               line_end, last_pix;
  rgb_t               rgb_c;

  assign line_end = (x_q == COORD_W'(WIDTH - 1));
  assign last_pix = line_end && (y_q == COORD_W'(HEIGHT - 1));

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next pixel is computed here so the colour of the pixel to present is registered directly.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    frame_nxt = frame_q;
    pat_nxt   = pat_q;
    solid_nxt = solid_q;
    valid_nxt = valid;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        valid_nxt = 1'b0;
        if (enable) begin
          state_nxt = ST_RUN;
          start     = 1'b1;
          x_nxt     = '0;
          y_nxt     = '0;
          valid_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (valid && ready) begin
          if (last_pix) begin
            x_nxt     = '0;
            y_nxt     = '0;
            frame_nxt = frame_q + FRAME_W'(1);
            if (enable) begin
              start = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
              valid_nxt = 1'b0;
            end
          end else if (line_end) begin
            x_nxt = '0;
            y_nxt = y_q + COORD_W'(1);
          end else begin
            x_nxt = x_q + COORD_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start) begin
      pat_nxt   = pattern_e'(pattern);
      solid_nxt = solid_rgb;
    end
    sof_nxt = valid_nxt && (x_nxt == '0) && (y_nxt == '0);
    eol_nxt = valid_nxt && (x_nxt == COORD_W'(WIDTH - 1));
  end

  pattern_map #(.WIDTH(WIDTH)) u_map (
    .x         (x_nxt),
    .y         (y_nxt),
    .frame     (frame_nxt),
    .pattern   (pat_nxt),
    .solid_rgb (solid_nxt),
    .rgb_c     (rgb_c)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      pat_q   <= PAT_GRAD;
      solid_q <= '0;
      valid   <= 1'b0;
      sof     <= 1'b0;
      eol     <= 1'b0;
      busy    <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      frame_q <= frame_nxt;
      pat_q   <= pat_nxt;
      solid_q <= solid_nxt;
      valid   <= valid_nxt;
      sof     <= sof_nxt;
      eol     <= eol_nxt;
      busy    <= (state_nxt == ST_RUN);
      r       <= valid_nxt ? rgb_c.r : 8'h00;
      g       <= valid_nxt ? rgb_c.g : 8'h00;
      b       <= valid_nxt ? rgb_c.b : 8'h00;
    end
  end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Self-checking bench for pixel_scan_gen (8x2 frame) against a pixel-index reference model.
module tb_pixel_scan_gen;

  localparam int W    = 8;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        aclk = 1'b0;
  logic        areset, enable, ready;
  logic [1:0]  pattern;
  logic [23:0] solid_rgb;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol, busy;

  pixel_scan_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .pattern(pattern),
    .solid_rgb(solid_rgb), .r(r), .g(g), .b(b), .valid(valid), .ready(ready),
    .sof(sof), .eol(eol), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [23:0] rgb;
    logic        sof;
    logic        eol;
    int          cyc;
  } pix_t;

  pix_t acc[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   chk_en = 0;

  // Reference model: frame position as a flat pixel index.
  bit          m_run = 0;
  int          m_idx = 0;
  int          m_frame = 0;
  int          m_pat = 0;
  logic [23:0] m_solid = '0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [23:0] exp_rgb(input int x, input int y, input int fr,
                                          input int pat, input logic [23:0] s);
    int xa = x;
    int bz = 0;
`ifdef PIXEL_SCAN_ANIMATE_EN
    xa = x + fr;
    bz = fr;
`endif
    case (pat)
      0:       return {8'(xa % 256), 8'(y % 256), 8'(bz)};
      1:       return (((xa / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
      2:       return BARS[x / (W / 8)];
      default: return s;
    endcase
  endfunction

  function automatic pix_t at(input int i);
    pix_t p;
    p = '{rgb: 'x, sof: 1'bx, eol: 1'bx, cyc: -1};
    if (i < acc.size()) p = acc[i];
    return p;
  endfunction

  always @(posedge aclk) begin
    cyc++;
    if (areset) begin
      m_run = 0; m_idx = 0; m_frame = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1; m_idx = 0; m_pat = int'(pattern); m_solid = solid_rgb;
      end
    end else if (ready) begin
      if (m_idx == NPIX - 1) begin
        m_idx = 0;
        m_frame = (m_frame + 1) % 256;
        if (enable) begin
          m_pat = int'(pattern); m_solid = solid_rgb;
        end else begin
          m_run = 0;
        end
      end else begin
        m_idx++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge aclk) begin
    if (chk_en) begin
      check("valid", 24'(valid), 24'(m_run));
      check("busy", 24'(busy), 24'(m_run));
      if (m_run) begin
        check("sof", 24'(sof), 24'(m_idx == 0));
        check("eol", 24'(eol), 24'((m_idx % W) == W - 1));
        check("rgb", {r, g, b}, exp_rgb(m_idx % W, m_idx / W, m_frame, m_pat, m_solid));
      end else begin
        check("sof_idle", 24'(sof), 24'h0);
        check("eol_idle", 24'(eol), 24'h0);
      end
    end
  end

  always @(negedge aclk) begin
    if (valid && ready) acc.push_back('{rgb: {r, g, b}, sof: sof, eol: eol, cyc: cyc});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick(1);
      k++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", max);
    end
  endtask

  initial begin
    areset = 1'b1; enable = 1'b0; ready = 1'b1; pattern = 2'd0; solid_rgb = '0;
    tick(3);
    @(negedge aclk);
    check("rst_valid", 24'(valid), 24'h0);
    check("rst_busy", 24'(busy), 24'h0);
    check("rst_sof", 24'(sof), 24'h0);
    check("rst_eol", 24'(eol), 24'h0);
    check("rst_rgb", {r, g, b}, 24'h000000);
    chk_en = 1;

    // Start with a single-cycle enable pulse.
    tick(1);
    areset = 1'b0; acc.delete(); pattern = 2'd0; enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(20);
    check("t1_count", 24'(acc.size()), 24'd16);
    check("t1_sof0", 24'(at(0).sof), 24'h1);
    check("t1_eol7", 24'(at(7).eol), 24'h1);
    check("t1_eol15", 24'(at(15).eol), 24'h1);
    check("t1_pix9", at(9).rgb, 24'h010100);
    check("t1_contig", 24'(at(15).cyc - at(0).cyc), 24'd15);
    check("t1_busy_end", 24'(busy), 24'h0);

    // Backpressure with ready 1,0,0,1.
    do_reset();
    acc.delete(); pattern = 2'd0; enable = 1'b1;
    tick(1);
    enable = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      tick(1);
    end
    ready = 1'b1;
    wait_idle(10);
    check("t2_count", 24'(acc.size()), 24'd16);
    for (int i = 0; i < 8; i++) begin
      check("t2_r_line0", 24'(at(i).rgb[23:16]), 24'(i));
      check("t2_g_line1", 24'(at(8 + i).rgb[15:8]), 24'h1);
    end

    // Back-to-back frames, then a third frame to observe frame counter 2.
    do_reset();
    acc.delete(); pattern = 2'd0; ready = 1'b1; enable = 1'b1;
    tick(20);
    enable = 1'b0;
    wait_idle(40);
    check("t3_count", 24'(acc.size()), 24'd32);
    check("t3_sof2", 24'(at(16).sof), 24'h1);
    check("t3_gap", 24'(at(16).cyc - at(15).cyc), 24'd1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_idle(40);
`ifdef PIXEL_SCAN_ANIMATE_EN
    check("t3_f1_pix0", at(16).rgb, 24'h010001);
    check("t3_f1_pix1", at(17).rgb, 24'h020001);
    check("t3_f2_pix0", at(32).rgb, 24'h020002);
`else
    check("t3_f1_pix0", at(16).rgb, 24'h000000);
    check("t3_f1_pix1", at(17).rgb, 24'h010000);
    check("t3_f2_pix0", at(32).rgb, 24'h000000);
`endif

    // Mid-frame pattern change takes effect only on the following frame.
    do_reset();
    acc.delete(); pattern = 2'd1; solid_rgb = 24'h123456; enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(5);
    pattern = 2'd3; enable = 1'b1;
    for (int k = 0; k < 40 && acc.size() < 17; k++) tick(1);
    enable = 1'b0;
    wait_idle(40);
    check("t4_pix5", at(5).rgb, 24'h000000);
    check("t4_pix15", at(15).rgb, 24'h000000);
    check("t4_next_pix0", at(16).rgb, 24'h123456);
    check("t4_next_pix15", at(31).rgb, 24'h123456);

    // Reset while showing pixel (3,1), then restart.
    do_reset();
    pattern = 2'd2; enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(11);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    @(negedge aclk);
    check("t5_valid", 24'(valid), 24'h0);
    check("t5_busy", 24'(busy), 24'h0);
    tick(1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    @(negedge aclk);
    check("t5_restart_valid", 24'(valid), 24'h1);
    check("t5_restart_sof", 24'(sof), 24'h1);
    check("t5_restart_rgb", {r, g, b}, 24'hFFFFFF);
    wait_idle(40);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      enable    = ($urandom % 4) != 0;
      ready     = ($urandom % 10) < 7;
      pattern   = 2'($urandom % 4);
      solid_rgb = 24'($urandom);
      areset    = ($urandom % 300) == 0;
      tick(1);
    end
    areset = 1'b0; enable = 1'b0; ready = 1'b1;
    wait_idle(40);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
